// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial receive path.
// Holds the FSM state set, payload width and half-bit helper.
package serial_pkg;
   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction
endpackage

// File: rtl/serial_rxd_if.sv
// Receiver-to-CPU bus: serial line in, byte plus ready/ack handshake out.
// The receiver uses the slave modport; the consumer side uses master.
interface serial_rxd_if;
   import serial_pkg::*;

   logic                 serialIn;
   logic                 rdAck;
   logic [DATA_BITS-1:0] out;
   logic                 RxRdy;
   logic                 frameErr;
   logic                 overrun;

   modport slave  (input  serialIn, rdAck, output out, RxRdy, frameErr, overrun);
   modport master (output serialIn, rdAck, input  out, RxRdy, frameErr, overrun);
endinterface

// File: rtl/serial_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Resets to 1 so a quiet line never looks like a start bit.
module serial_sync (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] ff_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ff_q <= 2'b11;
      else       ff_q <= {ff_q[0], d_i};
   end

   assign q_o = ff_q[1];
endmodule

// File: rtl/serial_rxd.sv
// UART receiver, 8N1, LSB first, single mid-bit sample per bit.
// Delivers bytes over a ready/ack handshake with framing-error and overrun flags.
module serial_rxd
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic         clk,
   input  logic         reset,
   serial_rxd_if.slave  bus
);
   localparam int HALF = half_bit(CLKS_PER_BIT);
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE  = IDLE;
   localparam logic [2:0] S_START = START;
   localparam logic [2:0] S_DATA  = DATA;
   localparam logic [2:0] S_STOP  = STOP;
   localparam logic [2:0] S_BREAK = BREAK;

   logic                 rx_s;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] out_q, out_d;
   logic                 rdy_q, rdy_d;
   logic                 ovr_q, ovr_d;
   logic                 ferr_q, ferr_d;
   logic                 good_stop;

   serial_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (bus.serialIn),
      .q_o   (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      ferr_d    = 1'b0;
      good_stop = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  good_stop = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // A line held low after a bad stop must go high before a new start counts.
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A completing frame takes priority over a same-cycle acknowledge.
   always_comb begin
      out_d = out_q;
      rdy_d = rdy_q;
      ovr_d = ovr_q;
      if (good_stop) begin
         out_d = shift_q;
         rdy_d = 1'b1;
         ovr_d = rdy_q & ~bus.rdAck;
      end else if (bus.rdAck && rdy_q) begin
         rdy_d = 1'b0;
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         out_q   <= '0;
         rdy_q   <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         out_q   <= out_d;
         rdy_q   <= rdy_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bus.out      = out_q;
   assign bus.RxRdy    = rdy_q;
   assign bus.overrun  = ovr_q;
   assign bus.frameErr = ferr_q;
endmodule

// File: tb/tb_serial_rxd.sv
// Self-checking bench for serial_rxd: directed scenarios plus a randomized
// 256-value sweep, all checked against a frame-level handshake model.
module tb_serial_rxd;
   localparam int CPB = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   serial_rxd_if bus ();

   serial_rxd #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Frame-level model of the CPU-facing state
   logic [7:0] m_out;
   logic       m_rdy;
   logic       m_ovr;

   task automatic model_reset();
      m_out = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack);
      if (stop) begin
         m_ovr = m_rdy && !ack;
         m_rdy = 1'b1;
         m_out = d;
      end else if (ack && m_rdy) begin
         m_rdy = 1'b0;
         m_ovr = 1'b0;
      end
   endtask

   // Called on a falling edge; returns one falling edge after the stop bit ends,
   // which is just after the receiver's stop-bit sample.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_at_stop);
      bus.serialIn = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.serialIn = d[i];
         repeat (CPB) @(negedge clk);
      end
      bus.serialIn = stop;
      repeat (CPB) @(negedge clk);
      bus.rdAck = ack_at_stop;
      @(negedge clk);
      bus.rdAck = 1'b0;
      model_frame(d, stop, ack_at_stop);
   endtask

   task automatic pulse_ack();
      bus.rdAck = 1'b1;
      @(negedge clk);
      bus.rdAck = 1'b0;
      if (m_rdy) begin
         m_rdy = 1'b0;
         m_ovr = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.serialIn = 1'b1;
      bus.rdAck = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun, bus.frameErr} !== 11'h000) begin
         failures++;
         $display("FAIL reset_values: out=%h rdy=%b ovr=%b ferr=%b, want 00 0 0 0",
                  bus.out, bus.RxRdy, bus.overrun, bus.frameErr);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      send_frame(8'hA5, 1'b1, 1'b0);
      checks++;
      if (bus.frameErr !== 1'b0) begin
         failures++;
         $display("FAIL single_ferr: got %b want 0", bus.frameErr);
      end
      @(negedge clk);
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL single_A5: out=%h rdy=%b ovr=%b want %h %b %b",
                  bus.out, bus.RxRdy, bus.overrun, m_out, m_rdy, m_ovr);
      end
      pulse_ack();
      checks++;
      if (bus.RxRdy !== 1'b0) begin
         failures++;
         $display("FAIL single_ack: rdy=%b want 0", bus.RxRdy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_glitch();
      logic seen = 1'b0;
      bus.serialIn = 1'b0;
      @(negedge clk);
      bus.serialIn = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus.RxRdy || bus.frameErr) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL glitch_quiet: outputs moved after glitch, want RxRdy=0 frameErr=0");
      end
      send_frame(8'h3C, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL glitch_next_3C: out=%h rdy=%b ovr=%b want %h %b %b",
                  bus.out, bus.RxRdy, bus.overrun, m_out, m_rdy, m_ovr);
      end
   endtask

   task automatic test_frame_err();
      logic extra = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b0);
      checks++;
      if (bus.frameErr !== 1'b1) begin
         failures++;
         $display("FAIL ferr_pulse: got %b want 1", bus.frameErr);
      end
      @(negedge clk);
      checks++;
      if (bus.frameErr !== 1'b0) begin
         failures++;
         $display("FAIL ferr_one_clk: got %b want 0", bus.frameErr);
      end
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL ferr_hold: out=%h rdy=%b ovr=%b want %h %b %b",
                  bus.out, bus.RxRdy, bus.overrun, m_out, m_rdy, m_ovr);
      end
      repeat (20) begin
         @(negedge clk);
         if (bus.frameErr) extra = 1'b1;
      end
      bus.serialIn = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.frameErr) extra = 1'b1;
      end
      checks++;
      if (extra || {bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL break_no_frame: extra_ferr=%b out=%h rdy=%b want %h %b",
                  extra, bus.out, bus.RxRdy, m_out, m_rdy);
      end
      pulse_ack();
      send_frame(8'h81, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL after_break_81: out=%h rdy=%b ovr=%b want %h %b %b",
                  bus.out, bus.RxRdy, bus.overrun, m_out, m_rdy, m_ovr);
      end
      pulse_ack();
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      send_frame(8'h22, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL overrun_set: out=%h rdy=%b ovr=%b want %h %b %b",
                  bus.out, bus.RxRdy, bus.overrun, m_out, m_rdy, m_ovr);
      end
      pulse_ack();
      checks++;
      if ({bus.RxRdy, bus.overrun} !== {m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL overrun_clear: rdy=%b ovr=%b want %b %b",
                  bus.RxRdy, bus.overrun, m_rdy, m_ovr);
      end
   endtask

   task automatic test_ack_collision();
      send_frame(8'h77, 1'b1, 1'b0);
      @(negedge clk);
      send_frame(8'h66, 1'b1, 1'b0);
      @(negedge clk);
      send_frame(8'h55, 1'b1, 1'b1);
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL ack_collision_55: out=%h rdy=%b ovr=%b want %h %b %b",
                  bus.out, bus.RxRdy, bus.overrun, m_out, m_rdy, m_ovr);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      logic seen = 1'b0;
      bus.serialIn = 1'b0;
      repeat (CPB) @(negedge clk);
      bus.serialIn = 1'b1;
      repeat (4 * CPB + 2) @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun, bus.frameErr} !== 11'h000) begin
         failures++;
         $display("FAIL reset_midframe: out=%h rdy=%b ovr=%b ferr=%b want 00 0 0 0",
                  bus.out, bus.RxRdy, bus.overrun, bus.frameErr);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.RxRdy || bus.frameErr) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL reset_partial: partial frame produced RxRdy/frameErr, want neither");
      end
      send_frame(8'h0F, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if ({bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
         failures++;
         $display("FAIL reset_then_0F: out=%h rdy=%b ovr=%b want %h %b %b",
                  bus.out, bus.RxRdy, bus.overrun, m_out, m_rdy, m_ovr);
      end
   endtask

   task automatic test_random_sweep();
      logic [7:0] d;
      logic       stop;
      logic       ack;
      for (int v = 0; v < 256; v++) begin
         d    = 8'(v);
         stop = ($urandom_range(0, 15) != 0);
         ack  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 1) pulse_ack();
         repeat ($urandom_range(0, 4)) @(negedge clk);
         send_frame(d, stop, ack);
         checks++;
         if (bus.frameErr !== !stop) begin
            failures++;
            $display("FAIL sweep_ferr[%0d]: got %b want %b", v, bus.frameErr, !stop);
         end
         @(negedge clk);
         checks++;
         if ({bus.out, bus.RxRdy, bus.overrun} !== {m_out, m_rdy, m_ovr}) begin
            failures++;
            $display("FAIL sweep[%0d]: out=%h rdy=%b ovr=%b want %h %b %b",
                     v, bus.out, bus.RxRdy, bus.overrun, m_out, m_rdy, m_ovr);
         end
         if (!stop) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            bus.serialIn = 1'b1;
            repeat (4) @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_ack_collision();
      test_reset_midframe();
      test_random_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
